gpio_edge_capture: RTL and testbench
====================================

// Module: gpio_edge_capture
// PURPOSE
//  Input conditioning stage between raw GPIO pins and the GPIO register block (its gpio_in).
//  - Synchronises each pin and debounces it.
//  - Drives the clean level downstream.
//  - Latches enabled rising/falling edges into sticky pending bits.
//  - Raises a maskable level interrupt. Register access is Wishbone classic, single-cycle ack.
// PARAMETERS
//  COUNT          32   number of GPIO lines, 1..32 (one 32-bit register per function)
//  DEBOUNCE_W     16   width of debounce prescaler and period register
//  DEBOUNCE_RST   0    reset value of DEBOUNCE register (0 = debounce bypassed)
// PORTS
//  wb_clk_i      in   1      single clock for all logic
//  wb_rst_i      in   1      reset, asynchronous, active-high
//  wb_cyc_i      in   1      Wishbone cycle
//  wb_stb_i      in   1      Wishbone strobe
//  wb_we_i       in   1      write enable
//  wb_sel_i      in   4      byte enables, honoured on writes
//  wb_adr_i      in   32     byte address; register select = wb_adr_i[4:2]
//  wb_dat_i      in   32     write data
//  wb_dat_o      out  32     read data, registered, valid with wb_ack_o
//  wb_ack_o      out  1      transfer acknowledge
//  wb_err_o      out  1      error acknowledge (unmapped register)
//  gpio_in       in   COUNT  raw asynchronous pin inputs
//  gpio_clean_o  out  COUNT  synchronised/debounced levels, feeds GPIO register block gpio_in
//  irq_o         out  1      interrupt, registered level
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0.
//    - Registers PENDING, RISE_EN, FALL_EN and IRQ_MASK reset to 0; DEBOUNCE resets to DEBOUNCE_RST.
//    - Synchronisers, sample history and clean levels reset to 0.
//    - A high pin after reset makes clean rise, but RISE_EN=0 means no pending bit is set.
//  Register map (adr[4:2]):
//    - 0 LEVEL: RO, clean levels.
//    - 1 PENDING: W1C, sticky.
//    - 2 RISE_EN, 3 FALL_EN, 4 IRQ_MASK: RW.
//    - 5 DEBOUNCE: RW, low DEBOUNCE_W bits; upper bits read 0.
//    - 6, 7: unmapped.
//    - Bits >= COUNT read 0; writes to them are ignored.
//  Bus:
//    - On cyc&stb with no ack/err asserted, exactly one of ack/err is asserted on the next cycle, for one cycle.
//    - Unmapped address gives err=1 and ack=0: no write, rdata 0.
//    - A write to LEVEL is acked and ignored.
//    - Writes are applied per byte lane where wb_sel_i[n]=1.
//  Sync: 2-flop synchroniser per bit.
//  Debounce:
//    - Prescaler counts 0..DEBOUNCE, then wraps; tick on wrap.
//    - On each tick, every bit shifts its synced value into a 2-deep history.
//    - clean <= history[0] when both entries agree.
//    - DEBOUNCE=0: bypass; clean <= synced every cycle, so pin->gpio_clean_o is 3 cycles.
//    - Writing DEBOUNCE clears the prescaler and history; the clean level is held.
//  Edges:
//    - rise = new_clean & ~clean, fall = ~new_clean & clean, evaluated the cycle clean updates.
//    - PENDING |= (rise&RISE_EN)|(fall&FALL_EN), visible the cycle after clean changes.
//    - A W1C clear and a new event on the same bit in the same cycle leave the bit SET.
//  irq_o <= |(PENDING & IRQ_MASK); one cycle after PENDING/IRQ_MASK change.
// STRUCTURE
//  Package gpio_edge_capture_pkg: register offset localparams (LEVEL..DEBOUNCE), register count.
//  Sub-module gpio_debounce_bit: one per line via generate.
//    - Ports: clk, rst, tick, bypass, in_sync, clean, rise, fall.
//    - Holds the synchroniser, history and clean flop.
//  Top level holds: prescaler, bus decode, registers, pending/irq logic.
// TESTING
//  1 DEBOUNCE=0, RISE_EN=1, MASK=1; pin0 0->1 at cycle t
//    -> gpio_clean_o[0]=1 at t+3, PENDING=0x1 at t+4, irq_o=1 at t+5.
//  2 DEBOUNCE=9; pulse pin3 high for 5 cycles -> clean never changes, PENDING stays 0.
//    Hold high for 40 cycles -> clean rises within 30 cycles.
//  3 PENDING=0x5; write PENDING 0x1 -> reads 0x4, irq follows.
//    Clear bit2 in the same cycle as a new fall on bit2 (FALL_EN=1) -> bit2 stays 1.
//  4 Read adr 0x18/0x1C -> err=1, ack=0, rdata 0.
//    Write RISE_EN=0xFFFFFFFF with sel=4'b0010 -> reads 0x0000FF00.
//  5 COUNT=8: write IRQ_MASK 0xFFFF -> reads 0xFF.
//    Back-to-back strobes -> ack pulses one cycle, never two in a row.
//  6 Assert wb_rst_i mid-debounce with events pending
//    -> all outputs and registers 0 immediately, DEBOUNCE=DEBOUNCE_RST.

Source files
------------

// File: rtl/gpio_edge_capture_pkg.sv
// gpio_edge_capture_pkg: register map and Wishbone helpers shared by the edge-capture block
package gpio_edge_capture_pkg;

    localparam logic [2:0] REG_LEVEL    = 3'd0;
    localparam logic [2:0] REG_PENDING  = 3'd1;
    localparam logic [2:0] REG_RISE_EN  = 3'd2;
    localparam logic [2:0] REG_FALL_EN  = 3'd3;
    localparam logic [2:0] REG_IRQ_MASK = 3'd4;
    localparam logic [2:0] REG_DEBOUNCE = 3'd5;
    localparam logic [2:0] REG_COUNT    = 3'd6;

    // expand the four byte enables into a 32-bit write mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_edge_capture_if.sv
// gpio_edge_capture_if: Wishbone classic register port of the edge-capture block
interface gpio_edge_capture_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: per-pin synchroniser, tick-sampled history, clean level and edge pulses
module gpio_debounce_bit (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic bypass,
    input  logic clr,
    input  logic in_sync,
    output logic clean,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q, sync_d;
    logic [1:0] hist_q, hist_d;
    logic       clean_q, clean_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic       synced;

    assign synced = sync_q[1];

    // sample history on ticks; the clean level follows once two consecutive samples agree
    always_comb begin
        sync_d  = {sync_q[0], in_sync};
        hist_d  = clr ? 2'b00 : (tick && !bypass) ? {hist_q[0], synced} : hist_q;
        clean_d = bypass ? synced : (tick && !clr && synced == hist_q[0]) ? synced : clean_q;
        rise_d  = clean_d & ~clean_q;
        fall_d  = ~clean_d & clean_q;
    end

    // state flops, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            hist_q  <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/gpio_edge_capture.sv
// gpio_edge_capture: synchronise, debounce and edge-capture GPIO pins behind a Wishbone register port
module gpio_edge_capture
    import gpio_edge_capture_pkg::*;
#(
    parameter int COUNT        = 32,
    parameter int DEBOUNCE_W   = 16,
    parameter int DEBOUNCE_RST = 0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    gpio_edge_capture_if.slave wb,
    input  logic [COUNT-1:0]   gpio_in,
    output logic [COUNT-1:0]   gpio_clean_o,
    output logic               irq_o
);

    logic                  req, wr, mapped, deb_wr, tick, bypass;
    logic [2:0]            idx;
    logic [31:0]           wmask32, rdata;
    logic [COUNT-1:0]      wmask, wdat, clean, rise, fall;
    logic [DEBOUNCE_W-1:0] deb_lane;
    logic [COUNT-1:0]      pend_q, pend_d;
    logic [COUNT-1:0]      rise_en_q, rise_en_d;
    logic [COUNT-1:0]      fall_en_q, fall_en_d;
    logic [COUNT-1:0]      mask_q, mask_d;
    logic [DEBOUNCE_W-1:0] deb_q, deb_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  irq_q, irq_d;
    logic [31:0]           dat_q, dat_d;
    logic                  unused_ok;

    // a new request is only taken while no acknowledge is outstanding
    assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign idx      = wb.wb_adr_i[4:2];
    assign mapped   = idx < REG_COUNT;
    assign wr       = req & wb.wb_we_i & mapped;
    assign deb_wr   = wr && idx == REG_DEBOUNCE;
    assign wmask32  = lane_mask(wb.wb_sel_i);
    assign wmask    = wmask32[COUNT-1:0];
    assign wdat     = wb.wb_dat_i[COUNT-1:0];
    assign deb_lane = wmask32[DEBOUNCE_W-1:0];
    assign tick     = cnt_q == deb_q;
    assign bypass   = deb_q == '0;
    assign unused_ok = ^{wb.wb_adr_i, wb.wb_dat_i, wmask32};

    for (genvar i = 0; i < COUNT; i++) begin : g_bit
        gpio_debounce_bit u_bit (
            .clk     (wb_clk_i),
            .rst     (wb_rst_i),
            .tick    (tick),
            .bypass  (bypass),
            .clr     (deb_wr),
            .in_sync (gpio_in[i]),
            .clean   (clean[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // read mux; bits above the implemented width read as zero
    always_comb begin
        rdata = '0;
        case (idx)
            REG_LEVEL:    rdata[COUNT-1:0]      = clean;
            REG_PENDING:  rdata[COUNT-1:0]      = pend_q;
            REG_RISE_EN:  rdata[COUNT-1:0]      = rise_en_q;
            REG_FALL_EN:  rdata[COUNT-1:0]      = fall_en_q;
            REG_IRQ_MASK: rdata[COUNT-1:0]      = mask_q;
            REG_DEBOUNCE: rdata[DEBOUNCE_W-1:0] = deb_q;
            default:      rdata                 = '0;
        endcase
    end

    // register, prescaler and bus next-state; new edge events win over a same-cycle W1C clear
    always_comb begin
        rise_en_d = (wr && idx == REG_RISE_EN)  ? (rise_en_q & ~wmask) | (wdat & wmask) : rise_en_q;
        fall_en_d = (wr && idx == REG_FALL_EN)  ? (fall_en_q & ~wmask) | (wdat & wmask) : fall_en_q;
        mask_d    = (wr && idx == REG_IRQ_MASK) ? (mask_q & ~wmask) | (wdat & wmask) : mask_q;
        deb_d     = deb_wr ? (deb_q & ~deb_lane) | (wb.wb_dat_i[DEBOUNCE_W-1:0] & deb_lane) : deb_q;
        pend_d    = (pend_q & ~((wr && idx == REG_PENDING) ? wdat & wmask : '0))
                  | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d     = |(pend_q & mask_q);
        cnt_d     = (deb_wr || tick) ? '0 : cnt_q + DEBOUNCE_W'(1);
        ack_d     = req & mapped;
        err_d     = req & ~mapped;
        dat_d     = (req && mapped && !wb.wb_we_i) ? rdata : '0;
    end

    // state flops, cleared asynchronously
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pend_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            mask_q    <= '0;
            deb_q     <= DEBOUNCE_W'(DEBOUNCE_RST);
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            mask_q    <= mask_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
            dat_q     <= dat_d;
        end
    end

    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_err_o  = err_q;
    assign wb.wb_dat_o  = dat_q;
    assign gpio_clean_o = clean;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_gpio_edge_capture.sv
// tb_gpio_edge_capture: scenario tasks plus a randomized bypass-mode run against a delay-line model
module tb_gpio_edge_capture;

    localparam logic [31:0] A_LEVEL = 32'h00, A_PEND = 32'h04, A_RISE = 32'h08;
    localparam logic [31:0] A_FALL = 32'h0C, A_MASK = 32'h10, A_DEB = 32'h14;
    localparam int NR = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] pins = '0;
    logic [31:0] clean;
    logic irq;
    logic [7:0] pins8 = '0;
    logic [7:0] clean8;
    logic irq8;
    int total = 0;
    int bad = 0;
    logic [31:0] rp[NR];
    logic [31:0] rp0;

    always #5 clk = ~clk;

    gpio_edge_capture_if bus();
    gpio_edge_capture_if bus8();

    gpio_edge_capture #(.COUNT(32), .DEBOUNCE_W(16), .DEBOUNCE_RST(0)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
        .gpio_in(pins), .gpio_clean_o(clean), .irq_o(irq)
    );

    gpio_edge_capture #(.COUNT(8), .DEBOUNCE_W(16), .DEBOUNCE_RST(0)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus8),
        .gpio_in(pins8), .gpio_clean_o(clean8), .irq_o(irq8)
    );

    // model: in bypass the clean level is the pin value driven three cycles earlier
    function automatic logic [31:0] model_clean(input int n);
        return (n - 3 < 0) ? rp0 : rp[n-3];
    endfunction

    task automatic idle();
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_sel_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        bus8.wb_cyc_i = 0; bus8.wb_stb_i = 0; bus8.wb_we_i = 0; bus8.wb_sel_i = 0; bus8.wb_adr_i = 0; bus8.wb_dat_i = 0;
    endtask

    task automatic drive(input bit b8, input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
        if (b8) begin
            bus8.wb_cyc_i = 1; bus8.wb_stb_i = 1; bus8.wb_we_i = we; bus8.wb_sel_i = sel; bus8.wb_adr_i = adr; bus8.wb_dat_i = wd;
        end else begin
            bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we; bus.wb_sel_i = sel; bus.wb_adr_i = adr; bus.wb_dat_i = wd;
        end
    endtask

    task automatic xfer(input bit b8, input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel,
                        output logic [31:0] rd, output logic ack, output logic err);
        drive(b8, we, adr, wd, sel);
        ack = 0; err = 0; rd = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            ack = b8 ? bus8.wb_ack_o : bus.wb_ack_o;
            err = b8 ? bus8.wb_err_o : bus.wb_err_o;
            rd  = b8 ? bus8.wb_dat_o : bus.wb_dat_o;
            if (ack || err) break;
        end
        idle();
        if (!(ack || err)) begin
            total++; bad++;
            $display("FAIL bus_timeout adr=%h got no ack/err required one", adr);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] d; logic a, e;
        xfer(0, 1, adr, wd, 4'hF, d, a, e);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        logic a, e;
        xfer(0, 0, adr, 0, 4'hF, d, a, e);
    endtask

    task automatic settle_clear();
        pins = 0;
        wr(A_DEB, 0); wr(A_RISE, 0); wr(A_FALL, 0); wr(A_MASK, 0);
        repeat (5) @(posedge clk); #1;
        wr(A_PEND, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1; pins = 0; idle();
        repeat (3) @(posedge clk); #1;
        total++;
        if (clean !== 0 || irq !== 0 || bus.wb_ack_o !== 0 || bus.wb_err_o !== 0 || bus.wb_dat_o !== 0) begin
            bad++; $display("FAIL reset_outputs got clean=%h irq=%b ack=%b err=%b dat=%h required all 0",
                            clean, irq, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o);
        end
        rst = 0;
        @(posedge clk); #1;
        for (int r = 0; r < 6; r++) begin
            rd(32'(r * 4), d);
            total++;
            if (d !== 0) begin bad++; $display("FAIL reset_reg%0d got=%h required=0", r, d); end
        end
    endtask

    task automatic test_bypass_timing();
        logic [31:0] d;
        wr(A_RISE, 1); wr(A_MASK, 1);
        pins[0] = 1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            total++;
            if (clean[0] !== (k >= 3)) begin bad++; $display("FAIL bypass_clean t+%0d got=%b required=%b", k, clean[0], k >= 3); end
            total++;
            if (irq !== (k >= 5)) begin bad++; $display("FAIL bypass_irq t+%0d got=%b required=%b", k, irq, k >= 5); end
        end
        rd(A_PEND, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL bypass_pending got=%h required=1", d); end
        settle_clear();
    endtask

    task automatic test_debounce();
        logic [31:0] d; bit moved; int first;
        wr(A_DEB, 9); wr(A_RISE, 8);
        pins[3] = 1;
        moved = 0;
        repeat (5) begin @(posedge clk); #1; if (clean !== 0) moved = 1; end
        pins[3] = 0;
        repeat (30) begin @(posedge clk); #1; if (clean !== 0) moved = 1; end
        total++;
        if (moved) begin bad++; $display("FAIL debounce_glitch clean changed got=1 required=0"); end
        rd(A_PEND, d);
        total++;
        if (d !== 0) begin bad++; $display("FAIL debounce_glitch_pending got=%h required=0", d); end
        pins[3] = 1;
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (clean[3] && first == 0) first = k;
        end
        total++;
        if (first < 10 || first > 30) begin bad++; $display("FAIL debounce_rise got cycle=%0d required 10..30", first); end
        rd(A_PEND, d);
        total++;
        if (d !== 32'h8) begin bad++; $display("FAIL debounce_pending got=%h required=8", d); end
        settle_clear();
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        wr(A_RISE, 5); wr(A_FALL, 4); wr(A_MASK, 5);
        pins = 5;
        repeat (6) @(posedge clk); #1;
        rd(A_PEND, d);
        total++;
        if (d !== 32'h5) begin bad++; $display("FAIL w1c_setup got=%h required=5", d); end
        wr(A_PEND, 1);
        rd(A_PEND, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL w1c_clear_bit0 got=%h required=4", d); end
        total++;
        if (irq !== 1) begin bad++; $display("FAIL w1c_irq_held got=%b required=1", irq); end
        wr(A_PEND, 4);
        total++;
        if (irq !== 1) begin bad++; $display("FAIL w1c_irq_lag got=%b required=1", irq); end
        @(posedge clk); #1;
        total++;
        if (irq !== 0) begin bad++; $display("FAIL w1c_irq_drop got=%b required=0", irq); end
        pins[2] = 0;
        repeat (3) @(posedge clk); #1;
        wr(A_PEND, 4);
        rd(A_PEND, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL w1c_collision got=%h required=4", d); end
        total++;
        if (irq !== 1) begin bad++; $display("FAIL w1c_collision_irq got=%b required=1", irq); end
        settle_clear();
    endtask

    task automatic test_bus();
        logic [31:0] d; logic a, e;
        for (int k = 0; k < 2; k++) begin
            xfer(0, 0, k == 0 ? 32'h18 : 32'h1C, 0, 4'hF, d, a, e);
            total++;
            if (e !== 1 || a !== 0 || d !== 0) begin
                bad++; $display("FAIL unmapped_read%0d got err=%b ack=%b dat=%h required err=1 ack=0 dat=0", k, e, a, d);
            end
            @(posedge clk); #1;
            total++;
            if (bus.wb_err_o !== 0) begin bad++; $display("FAIL err_single_cycle got=%b required=0", bus.wb_err_o); end
        end
        xfer(0, 1, A_LEVEL, 32'hFFFF_FFFF, 4'hF, d, a, e);
        total++;
        if (a !== 1 || e !== 0) begin bad++; $display("FAIL level_write got ack=%b err=%b required ack=1 err=0", a, e); end
        xfer(0, 1, A_RISE, 32'hFFFF_FFFF, 4'b0010, d, a, e);
        rd(A_RISE, d);
        total++;
        if (d !== 32'h0000_FF00) begin bad++; $display("FAIL byte_lane got=%h required=0000ff00", d); end
        wr(A_DEB, 32'hFFFF_FFFF);
        rd(A_DEB, d);
        total++;
        if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL debounce_width got=%h required=0000ffff", d); end
        settle_clear();
    endtask

    task automatic test_count8();
        logic [31:0] d; logic a, e, prev; int acks, doubles;
        xfer(1, 1, A_MASK, 32'hFFFF, 4'hF, d, a, e);
        xfer(1, 0, A_MASK, 0, 4'hF, d, a, e);
        total++;
        if (d !== 32'hFF) begin bad++; $display("FAIL count8_mask got=%h required=ff", d); end
        drive(1, 0, A_MASK, 0, 4'hF);
        prev = 0; acks = 0; doubles = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus8.wb_ack_o) acks++;
            if (bus8.wb_ack_o && prev) doubles++;
            prev = bus8.wb_ack_o;
        end
        idle();
        total++;
        if (doubles != 0) begin bad++; $display("FAIL b2b_double_ack got=%0d required=0", doubles); end
        total++;
        if (acks != 5) begin bad++; $display("FAIL b2b_ack_count got=%0d required=5", acks); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] re, fe, mk, pend, c1, c2, d; logic exp_irq;
        re = $urandom; fe = $urandom; mk = $urandom; rp0 = $urandom;
        wr(A_RISE, re); wr(A_FALL, fe); wr(A_MASK, mk);
        pins = rp0;
        repeat (6) @(posedge clk); #1;
        wr(A_PEND, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk); #1;
        pend = 0;
        for (int i = 0; i < NR; i++) begin
            c1 = (i == 0) ? rp0 : rp[i-1];
            rp[i] = (i >= NR - 8) ? c1 : c1 ^ ($urandom & $urandom & $urandom);
            pins = rp[i];
            @(posedge clk); #1;
            exp_irq = |(pend & mk);
            c1 = model_clean(i);
            c2 = model_clean(i - 1);
            pend |= (c1 & ~c2 & re) | (~c1 & c2 & fe);
            total++;
            if (clean !== model_clean(i + 1)) begin bad++; $display("FAIL rand_clean n=%0d got=%h required=%h", i + 1, clean, model_clean(i + 1)); end
            total++;
            if (irq !== exp_irq) begin bad++; $display("FAIL rand_irq n=%0d got=%b required=%b", i + 1, irq, exp_irq); end
        end
        rd(A_PEND, d);
        total++;
        if (d !== pend) begin bad++; $display("FAIL rand_pending got=%h required=%h", d, pend); end
        settle_clear();
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        wr(A_RISE, 32'hFF); wr(A_MASK, 32'hFF);
        pins = 32'hF0;
        repeat (6) @(posedge clk); #1;
        total++;
        if (irq !== 1) begin bad++; $display("FAIL areset_precondition irq got=%b required=1", irq); end
        wr(A_DEB, 7);
        pins = 32'h0F;
        repeat (4) @(posedge clk);
        #4 rst = 1;
        #1;
        total++;
        if (clean !== 0 || irq !== 0 || bus.wb_ack_o !== 0 || bus.wb_err_o !== 0 || bus.wb_dat_o !== 0) begin
            bad++; $display("FAIL areset_outputs got clean=%h irq=%b ack=%b err=%b dat=%h required all 0",
                            clean, irq, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o);
        end
        @(posedge clk); #1;
        rst = 0;
        for (int r = 1; r < 6; r++) begin
            rd(32'(r * 4), d);
            total++;
            if (d !== 0) begin bad++; $display("FAIL areset_reg%0d got=%h required=0", r, d); end
        end
        repeat (4) @(posedge clk); #1;
        rd(A_LEVEL, d);
        total++;
        if (d !== 32'h0F) begin bad++; $display("FAIL areset_level got=%h required=0000000f", d); end
        rd(A_PEND, d);
        total++;
        if (d !== 0 || irq !== 0) begin bad++; $display("FAIL areset_no_pending got pend=%h irq=%b required 0/0", d, irq); end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass_timing();
        test_debounce();
        test_w1c();
        test_bus();
        test_count8();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
